trajectory_integrator: RTL

- Downstream stage of the altitude calculator. Consumes the per-step altitude and distance increments it produces and accumulates them into absolute altitude and downrange distance.
- Feeds the accumulated altitude back to the calculator as its current_altitude input.
- Runs a flight-phase state machine that terminates on target altitude, step timeout, or arithmetic overflow.

---
 rtl/trajectory_pkg.sv | 31 +++
 rtl/trajectory_integrator_if.sv | 32 +++
 rtl/traj_sat_add.sv | 34 +++
 rtl/trajectory_integrator.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/trajectory_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trajectory_pkg
//  Purpose  : Shared widths, FSM state type and termination status codes for
//             the trajectory integrator slice.
//  Revision : 1.0  initial release
// ============================================================================
package trajectory_pkg;

  // Default word widths: 1 LSB of altitude/distance = 1e-9 m
  localparam int N_DEF     = 64;
  localparam int CNT_W_DEF = 32;

  // 188 km expressed in 1e-9 m LSBs
  localparam logic signed [63:0] TARGET_ALT_DEF = 64'sd188000000000000;

  // Flight-phase states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } traj_state_t;

  // Termination reasons reported on status
  localparam logic [1:0] ST_NONE     = 2'd0;
  localparam logic [1:0] ST_TARGET   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;
  localparam logic [1:0] ST_OVERFLOW = 2'd3;

endpackage : trajectory_pkg
`default_nettype wire

// File: rtl/trajectory_integrator_if.sv
`default_nettype none
// ============================================================================
//  Module   : trajectory_integrator_if
//  Purpose  : Increment-pair handshake from the altitude calculator into the
//             integrator. master = upstream producer, slave = integrator.
//  Revision : 1.0  initial release
// ============================================================================
interface trajectory_integrator_if
  import trajectory_pkg::*;
#(
  parameter int N = N_DEF
);
  logic         in_valid;
  logic [N-1:0] frac_altitude;
  logic [N-1:0] frac_distance;
  logic         in_ready;

  modport master (
    output in_valid,
    output frac_altitude,
    output frac_distance,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  frac_altitude,
    input  frac_distance,
    output in_ready
  );
endinterface : trajectory_integrator_if
`default_nettype wire

// File: rtl/traj_sat_add.sv
`default_nettype none
// ============================================================================
//  Module   : traj_sat_add
//  Purpose  : Signed N-bit adder that clamps to the most positive / most
//             negative value on overflow and flags the event.
//  Revision : 1.0  initial release
// ============================================================================
module traj_sat_add #(
  parameter int N = 64
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] sum,
  output logic                overflow
);

  logic signed [N-1:0] w_raw;

  assign w_raw = a + b;

  // Overflow only possible when both operands share a sign and the wrapped
  // result does not.
  assign overflow = (a[N-1] == b[N-1]) && (w_raw[N-1] != a[N-1]);

  // Clamp toward the sign of the operands when the wrapped sum is invalid
  always_comb begin
    sum = w_raw;
    if (overflow) begin
      sum = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

endmodule : traj_sat_add
`default_nettype wire

// File: rtl/trajectory_integrator.sv
`default_nettype none
// ============================================================================
//  Module   : trajectory_integrator
//  Purpose  : Accumulates per-step altitude/distance increments into absolute
//             altitude and downrange distance, and runs the flight-phase FSM
//             that stops on target altitude, step timeout or overflow.
//  Options  : define TRAJ_APOGEE_EN to enable apogee tracking
//             (apogee_altitude / apogee_pulse); otherwise both read 0.
//  Revision : 1.0  initial release
// ============================================================================
module trajectory_integrator
  import trajectory_pkg::*;
#(
  parameter int                N          = N_DEF,
  parameter int                CNT_W      = CNT_W_DEF,
  parameter logic signed [N-1:0] TARGET_ALT = TARGET_ALT_DEF,
  parameter int                MAX_STEPS  = 1_000_000
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    start,
  input  logic [N-1:0]            init_altitude,
  input  logic [N-1:0]            init_distance,
  trajectory_integrator_if.slave  inc,
  output logic [N-1:0]            current_altitude,
  output logic [N-1:0]            total_distance,
  output logic [CNT_W-1:0]        step_count,
  output logic                    running,
  output logic                    done,
  output logic [1:0]              status,
  output logic [N-1:0]            apogee_altitude,
  output logic                    apogee_pulse
);

  traj_state_t         r_state;
  logic signed [N-1:0] r_alt;
  logic signed [N-1:0] r_dist;
  logic [CNT_W-1:0]    r_step;
  logic [1:0]          r_status;

  logic signed [N-1:0] w_alt_sum;
  logic signed [N-1:0] w_dist_sum;
  logic                w_alt_ovf;
  logic                w_dist_ovf;
  logic                w_accept;
  logic [CNT_W-1:0]    w_step_next;

  // Ready is a pure function of state so the upstream sees it immediately
  assign inc.in_ready = (r_state == RUN);

  // A start in the same cycle takes precedence and drops the increment
  assign w_accept    = inc.in_valid && (r_state == RUN) && !start;
  assign w_step_next = r_step + 1'b1;

  traj_sat_add #(.N(N)) u_alt_add (
    .a        (r_alt),
    .b        (inc.frac_altitude),
    .sum      (w_alt_sum),
    .overflow (w_alt_ovf)
  );

  traj_sat_add #(.N(N)) u_dist_add (
    .a        (r_dist),
    .b        (inc.frac_distance),
    .sum      (w_dist_sum),
    .overflow (w_dist_ovf)
  );

  // Flight-phase FSM and accumulators; termination is judged on the
  // post-accept values so final values and done appear in the same cycle.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state  <= IDLE;
      r_alt    <= '0;
      r_dist   <= '0;
      r_step   <= '0;
      r_status <= ST_NONE;
    end else if (start) begin
      r_state  <= RUN;
      r_alt    <= init_altitude;
      r_dist   <= init_distance;
      r_step   <= '0;
      r_status <= ST_NONE;
    end else begin
      case (r_state)
        RUN: begin
          if (w_accept) begin
            r_alt  <= w_alt_sum;
            r_dist <= w_dist_sum;
            r_step <= w_step_next;
            if (w_alt_ovf || w_dist_ovf) begin
              r_state  <= DONE;
              r_status <= ST_OVERFLOW;
            end else if (w_alt_sum >= TARGET_ALT) begin
              r_state  <= DONE;
              r_status <= ST_TARGET;
            end else if (w_step_next == CNT_W'(MAX_STEPS)) begin
              r_state  <= DONE;
              r_status <= ST_TIMEOUT;
            end
          end
        end
        IDLE, DONE: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign current_altitude = r_alt;
  assign total_distance   = r_dist;
  assign step_count       = r_step;
  assign status           = r_status;
  assign running          = (r_state == RUN);
  assign done             = (r_state == DONE);

`ifdef TRAJ_APOGEE_EN
  logic signed [N-1:0] r_apogee;
  logic                r_seen_rise;
  logic                r_fired;
  logic                r_pulse;
  logic                w_frac_pos;
  logic                w_frac_neg;

  assign w_frac_neg = inc.frac_altitude[N-1];
  assign w_frac_pos = !inc.frac_altitude[N-1] && (|inc.frac_altitude);

  // Peak tracking and one-shot apogee detection (first fall after a rise)
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_apogee    <= '0;
      r_seen_rise <= 1'b0;
      r_fired     <= 1'b0;
      r_pulse     <= 1'b0;
    end else if (start) begin
      r_apogee    <= init_altitude;
      r_seen_rise <= 1'b0;
      r_fired     <= 1'b0;
      r_pulse     <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (w_accept) begin
        if (w_alt_sum > r_apogee) begin
          r_apogee <= w_alt_sum;
        end
        if (w_frac_pos) begin
          r_seen_rise <= 1'b1;
        end
        if (w_frac_neg && r_seen_rise && !r_fired) begin
          r_pulse <= 1'b1;
          r_fired <= 1'b1;
        end
      end
    end
  end

  assign apogee_altitude = r_apogee;
  assign apogee_pulse    = r_pulse;
`else
  assign apogee_altitude = '0;
  assign apogee_pulse    = 1'b0;
`endif

endmodule : trajectory_integrator
`default_nettype wire
